obf_sub_seq: RTL and testbench

Programmable substitution sequencer for the OR1200 hardware obfuscator. It is the next-generation replacement for the fixed combinational substitution table. For each instruction-group ID handed over by the IGU, it emits a stream of substitute-instruction descriptors, one per handshake. The substitution table is runtime-writable through a configuration port. The block sits between the IGU and the instruction-synthesis stage, and applies backpressure through valid/ready handshakes.

---
 rtl/obf_sub_seq.sv | 214 +++++++++++++++++++++
 tb/tb_obf_sub_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obf_sub_seq.sv
// obf_sub_seq
//
// Programmable substitution sequencer for the OR1200 hardware obfuscator.
// For every instruction-group ID accepted from the IGU it streams a sequence
// of substitute-instruction descriptors, one per output handshake. The
// sequences live in a runtime-writable table of NUM_SLOTS slots, each with a
// valid bit, an IGU tag and MAX_SEQ words of {type, field, last}.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears table)
//   flush               synchronous abort of the current sequence
//   req_valid/req_ready request handshake, req_igu = group ID to substitute
//   out_valid/out_ready descriptor handshake
//   out_type/out_field  descriptor insn type and template field
//   out_last            final descriptor of the sequence
//   out_sub             substitution index of the descriptor
//   out_hit             1 = word from a programmed slot, 0 = miss word
//   cfg_ready           table writable (IDLE and no request being accepted)
//   cfg_we              write cfg_word to word cfg_idx of slot cfg_slot
//   cfg_tag_we          write cfg_tag/cfg_valid of slot cfg_slot
module obf_sub_seq #(
    parameter int unsigned IGU_WIDTH   = 7,
    parameter int unsigned SUB_WIDTH   = 3,
    parameter int unsigned NUM_SLOTS   = 8,
    parameter int unsigned TYPE_WIDTH  = 3,
    parameter int unsigned FIELD_WIDTH = 16,
    // Encoding of OBF_INSN_TYPE_N
    parameter logic [TYPE_WIDTH-1:0] MISS_TYPE = TYPE_WIDTH'(4),
    localparam int unsigned WORD_W = TYPE_WIDTH + FIELD_WIDTH + 1,
    localparam int unsigned SLOT_W = $clog2(NUM_SLOTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IGU_WIDTH-1:0]   req_igu,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TYPE_WIDTH-1:0]  out_type,
    output logic [FIELD_WIDTH-1:0] out_field,
    output logic                   out_last,
    output logic [SUB_WIDTH-1:0]   out_sub,
    output logic                   out_hit,

    output logic                   cfg_ready,
    input  logic                   cfg_we,
    input  logic                   cfg_tag_we,
    input  logic [SLOT_W-1:0]      cfg_slot,
    input  logic [SUB_WIDTH-1:0]   cfg_idx,
    input  logic [WORD_W-1:0]      cfg_word,
    input  logic [IGU_WIDTH-1:0]   cfg_tag,
    input  logic                   cfg_valid
);

    localparam int unsigned MAX_SEQ = 1 << SUB_WIDTH;
    localparam logic [SUB_WIDTH-1:0] SUB_MAX = '1;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    // ------------------------------------------------------------------
    // Substitution table
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]    mem_q      [NUM_SLOTS][MAX_SEQ];
    logic [IGU_WIDTH-1:0] tag_q      [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_vld_q;

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------
    state_t                 state_q,     state_d;
    logic                   out_valid_q, out_valid_d;
    logic [TYPE_WIDTH-1:0]  out_type_q,  out_type_d;
    logic [FIELD_WIDTH-1:0] out_field_q, out_field_d;
    logic                   out_last_q,  out_last_d;
    logic [SUB_WIDTH-1:0]   out_sub_q,   out_sub_d;
    logic                   out_hit_q,   out_hit_d;
    logic [SLOT_W-1:0]      slot_q,      slot_d;

    logic                   accept;
    logic                   lk_hit;
    logic [SLOT_W-1:0]      lk_slot;
    logic [SUB_WIDTH-1:0]   sub_nxt;
    logic [SLOT_W-1:0]      slot_sel;
    logic [SUB_WIDTH-1:0]   idx_sel;
    logic [WORD_W-1:0]      ld_word;
    logic                   ld_last;
    logic                   cfg_wr_ok;

    // Parallel tag match. Scanning from the highest slot down lets the
    // lowest-numbered matching slot overwrite any higher match.
    always_comb begin
        lk_hit  = 1'b0;
        lk_slot = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (slot_vld_q[SLOT_W'(NUM_SLOTS - 1 - i)] &&
                (tag_q[SLOT_W'(NUM_SLOTS - 1 - i)] == req_igu)) begin
                lk_hit  = 1'b1;
                lk_slot = SLOT_W'(NUM_SLOTS - 1 - i);
            end
        end
    end

    // A new sequence can start in IDLE or as the previous one's last
    // descriptor is consumed; flush blocks both.
    assign req_ready = !flush &&
                       ((state_q == ST_IDLE) || (out_valid_q && out_ready && out_last_q));
    assign accept    = req_valid && req_ready;
    assign cfg_ready = (state_q == ST_IDLE) && !accept;
    assign cfg_wr_ok = cfg_ready;

    // Single word-read port: word 0 of the looked-up slot on accept,
    // otherwise the next word of the latched slot.
    assign sub_nxt  = out_sub_q + 1'b1;
    assign slot_sel = accept ? lk_slot : slot_q;
    assign idx_sel  = accept ? '0 : sub_nxt;
    assign ld_word  = mem_q[slot_sel][idx_sel];
    // The final table word always terminates, so the index never wraps.
    assign ld_last  = ld_word[0] || (idx_sel == SUB_MAX);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_type_d  = out_type_q;
        out_field_d = out_field_q;
        out_last_d  = out_last_q;
        out_sub_d   = out_sub_q;
        out_hit_d   = out_hit_q;
        slot_d      = slot_q;

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else if (accept) begin
            state_d     = ST_EMIT;
            out_valid_d = 1'b1;
            out_sub_d   = '0;
            out_hit_d   = lk_hit;
            slot_d      = lk_slot;
            if (lk_hit) begin
                out_type_d  = ld_word[WORD_W-1 -: TYPE_WIDTH];
                out_field_d = ld_word[FIELD_WIDTH:1];
                out_last_d  = ld_last;
            end else begin
                out_type_d  = MISS_TYPE;
                out_field_d = '0;
                out_last_d  = 1'b1;
            end
        end else if ((state_q == ST_EMIT) && out_ready) begin
            if (!out_last_q) begin
                out_type_d  = ld_word[WORD_W-1 -: TYPE_WIDTH];
                out_field_d = ld_word[FIELD_WIDTH:1];
                out_last_d  = ld_last;
                out_sub_d   = sub_nxt;
            end else begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_type_q  <= '0;
            out_field_q <= '0;
            out_last_q  <= 1'b0;
            out_sub_q   <= '0;
            out_hit_q   <= 1'b0;
            slot_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_type_q  <= out_type_d;
            out_field_q <= out_field_d;
            out_last_q  <= out_last_d;
            out_sub_q   <= out_sub_d;
            out_hit_q   <= out_hit_d;
            slot_q      <= slot_d;
        end
    end

    // Table writes are only taken in IDLE, so an active sequence always
    // reads a stable slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            tag_q      <= '{default: '0};
            slot_vld_q <= '0;
        end else if (cfg_wr_ok) begin
            if (cfg_we) begin
                mem_q[cfg_slot][cfg_idx] <= cfg_word;
            end
            if (cfg_tag_we) begin
                tag_q[cfg_slot]      <= cfg_tag;
                slot_vld_q[cfg_slot] <= cfg_valid;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_type  = out_type_q;
    assign out_field = out_field_q;
    assign out_last  = out_last_q;
    assign out_sub   = out_sub_q;
    assign out_hit   = out_hit_q;

endmodule

// File: tb/tb_obf_sub_seq.sv
// Testbench for obf_sub_seq: a reference table model produces the expected
// descriptor stream for each accepted request; a monitor pops and compares
// every consumed descriptor and checks stability while stalled.
module tb_obf_sub_seq;

    localparam logic [2:0] MISS_T = 3'd4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_igu;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_type;
    logic [15:0] out_field;
    logic        out_last;
    logic [2:0]  out_sub;
    logic        out_hit;
    logic        cfg_ready;
    logic        cfg_we;
    logic        cfg_tag_we;
    logic [2:0]  cfg_slot;
    logic [2:0]  cfg_idx;
    logic [19:0] cfg_word;
    logic [6:0]  cfg_tag;
    logic        cfg_valid;

    obf_sub_seq #(
        .IGU_WIDTH  (7),
        .SUB_WIDTH  (3),
        .NUM_SLOTS  (8),
        .TYPE_WIDTH (3),
        .FIELD_WIDTH(16),
        .MISS_TYPE  (MISS_T)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_igu   (req_igu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_type  (out_type),
        .out_field (out_field),
        .out_last  (out_last),
        .out_sub   (out_sub),
        .out_hit   (out_hit),
        .cfg_ready (cfg_ready),
        .cfg_we    (cfg_we),
        .cfg_tag_we(cfg_tag_we),
        .cfg_slot  (cfg_slot),
        .cfg_idx   (cfg_idx),
        .cfg_word  (cfg_word),
        .cfg_tag   (cfg_tag),
        .cfg_valid (cfg_valid)
    );

    typedef struct {
        logic [23:0] d;
        bit          gap;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          mode  = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: manual

    logic [19:0] m_mem [8][8];
    logic [6:0]  m_tag [8];
    bit          m_vld [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            m_tag[s] = '0;
            m_vld[s] = 1'b0;
            for (int k = 0; k < 8; k++) m_mem[s][k] = '0;
        end
    endtask

    // Expected descriptor stream for a request, from the model table.
    task automatic push_seq(input logic [6:0] igu, input bit gap_first, input bit gap_rest);
        int   slot = -1;
        exp_t e;
        for (int s = 0; s < 8; s++)
            if (slot < 0 && m_vld[s] && m_tag[s] == igu) slot = s;
        if (slot < 0) begin
            e.d   = {MISS_T, 16'h0000, 1'b1, 3'd0, 1'b0};
            e.gap = gap_first;
            exp_q.push_back(e);
        end else begin
            for (int k = 0; k < 8; k++) begin
                logic [19:0] w;
                logic        last;
                w     = m_mem[slot][k];
                last  = w[0] || (k == 7);
                e.d   = {w[19:17], w[16:1], last, 3'(k), 1'b1};
                e.gap = (k == 0) ? gap_first : gap_rest;
                exp_q.push_back(e);
                if (last) break;
            end
        end
    endtask

    task automatic send_req(input logic [6:0] igu, input bit gap_first, input bit gap_rest);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_igu   = igu;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        chk("req_accept", 32'(ok), 1);
        if (ok) push_seq(igu, gap_first, gap_rest);
        sync();
        req_valid = 1'b0;
    endtask

    task automatic cfg_go();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cfg_ready) ok = 1'b1;
        end
        chk("cfg_ready_wait", 32'(ok), 1);
        sync();
        cfg_we     = 1'b0;
        cfg_tag_we = 1'b0;
    endtask

    task automatic cfg_wr_word(input int slot, input int idx, input logic [19:0] w);
        cfg_we   = 1'b1;
        cfg_slot = 3'(slot);
        cfg_idx  = 3'(idx);
        cfg_word = w;
        cfg_go();
        m_mem[slot][idx] = w;
    endtask

    task automatic cfg_wr_tag(input int slot, input logic [6:0] tag, input bit v);
        cfg_tag_we = 1'b1;
        cfg_slot   = 3'(slot);
        cfg_tag    = tag;
        cfg_valid  = v;
        cfg_go();
        m_tag[slot] = tag;
        m_vld[slot] = v;
    endtask

    task automatic cfg_wr_both(input int slot, input int idx, input logic [19:0] w,
                               input logic [6:0] tag, input bit v);
        cfg_we     = 1'b1;
        cfg_tag_we = 1'b1;
        cfg_slot   = 3'(slot);
        cfg_idx    = 3'(idx);
        cfg_word   = w;
        cfg_tag    = tag;
        cfg_valid  = v;
        cfg_go();
        m_mem[slot][idx] = w;
        m_tag[slot]      = tag;
        m_vld[slot]      = v;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
        end
        chk("drain", 32'(exp_q.size()), 0);
        sync();
    endtask

    // out_ready driver for the automatic modes
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = (cyc % 3 == 0);
        end
    end

    // Output monitor
    logic [23:0] mon_d;
    logic [23:0] held_d;
    bit          held;
    int          last_x;
    exp_t        mon_e;

    initial begin
        held   = 1'b0;
        held_d = '0;
        last_x = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                mon_d = {out_type, out_field, out_last, out_sub, out_hit};
                if (held && out_valid) chk("hold_stable", 32'(mon_d), 32'(held_d));
                if (out_valid && out_ready && !flush) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_desc", 32'(exp_q.size()), 1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("desc", 32'(mon_d), 32'(mon_e.d));
                        if (mon_e.gap) chk("no_bubble", 32'(cyc - last_x), 1);
                    end
                    last_x = cyc;
                end
                held   = out_valid && !out_ready && !flush;
                held_d = mon_d;
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_igu    = '0;
        cfg_we     = 1'b0;
        cfg_tag_we = 1'b0;
        cfg_slot   = '0;
        cfg_idx    = '0;
        cfg_word   = '0;
        cfg_tag    = '0;
        cfg_valid  = 1'b0;
        mode       = 0;
        model_clear();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_outputs", 32'({out_valid, out_type, out_field, out_last, out_sub, out_hit}), 0);
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        sync();
        rst_n = 1'b1;
        sync();

        // Unprogrammed table: miss word
        send_req(7'd64, 1'b0, 1'b0);
        wait_drain();
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 1);
        chk("idle_cfg_ready", 32'(cfg_ready), 1);
        sync();

        // Slot 0: three-word sequence, full throughput
        cfg_wr_word(0, 0, {3'd2, 16'h00A0, 1'b0});
        cfg_wr_word(0, 1, {3'd2, 16'h0150, 1'b0});
        cfg_wr_word(0, 2, {3'd2, 16'h05E0, 1'b1});
        cfg_wr_tag(0, 7'd64, 1'b1);
        send_req(7'd64, 1'b0, 1'b1);
        wait_drain();

        // Same request under backpressure
        mode = 1;
        send_req(7'd64, 1'b0, 1'b0);
        wait_drain();
        mode = 0;
        sync();

        // Slot 1: no last bits, forced termination, back-to-back follow-on
        for (int k = 0; k < 8; k++) cfg_wr_word(1, k, {3'd5, 16'h1000 + 16'(k * 3), 1'b0});
        cfg_wr_tag(1, 7'd9, 1'b1);
        send_req(7'd9, 1'b0, 1'b1);
        send_req(7'd64, 1'b1, 1'b1);
        wait_drain();

        // Flush during sub=1
        mode      = 2;
        out_ready = 1'b0;
        sync();
        send_req(7'd64, 1'b0, 1'b0);
        out_ready = 1'b1;
        sync();
        out_ready = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        chk("sub_at_flush", 32'(out_sub), 1);
        chk("req_ready_in_flush", 32'(req_ready), 0);
        sync();
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("valid_after_flush", 32'(out_valid), 0);
        chk("idle_after_flush", 32'({req_ready, cfg_ready}), 3);
        sync();
        out_ready = 1'b1;
        send_req(7'd64, 1'b0, 1'b1);
        wait_drain();

        // Duplicate tags: lowest slot wins; combined word+tag write on slot 5
        mode = 0;
        cfg_wr_both(5, 0, {3'd6, 16'h5555, 1'b1}, 7'd33, 1'b1);
        cfg_wr_word(2, 0, {3'd1, 16'hBEEF, 1'b0});
        cfg_wr_word(2, 1, {3'd1, 16'h2222, 1'b1});
        cfg_wr_tag(2, 7'd33, 1'b1);
        send_req(7'd33, 1'b0, 1'b1);
        wait_drain();

        // Config writes attempted mid-sequence are ignored
        mode      = 2;
        out_ready = 1'b0;
        sync();
        send_req(7'd33, 1'b0, 1'b0);
        cfg_we     = 1'b1;
        cfg_tag_we = 1'b1;
        cfg_slot   = 3'd2;
        cfg_idx    = 3'd0;
        cfg_word   = 20'hFFFFF;
        cfg_tag    = 7'd0;
        cfg_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("cfg_ready_busy", 32'(cfg_ready), 0);
            sync();
        end
        cfg_we     = 1'b0;
        cfg_tag_we = 1'b0;
        out_ready  = 1'b1;
        wait_drain();
        send_req(7'd33, 1'b0, 1'b1);
        wait_drain();

        // Asynchronous reset mid-sequence clears state and table
        out_ready = 1'b0;
        send_req(7'd64, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_sub_hit", 32'({out_sub, out_hit, out_last}), 0);
        exp_q.delete();
        model_clear();
        sync();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sync();
        send_req(7'd64, 1'b0, 1'b0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
